relax_osc_freq_meter: RTL and testbench

Digital frequency meter that consumes the relaxation oscillator's comparator output, routed back in through a digital input pin, and reports its frequency as a rising-edge count over a programmable gate window of `clk` cycles. It sits directly downstream of the analog oscillator macro in the same tile. It provides single-shot and continuous measurement, saturating counts with an overflow flag, and an 8-bit byte-multiplexed readout sized for the `uo_out` pins.

---
 rtl/relax_osc_freq_meter_if.sv | 25 ++
 rtl/relax_osc_freq_meter.sv | 135 +++++++++++++
 tb/tb_relax_osc_freq_meter.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/relax_osc_freq_meter_if.sv
// Control/result bundle of the relaxation-oscillator frequency meter.
// master = controlling logic, slave = the meter.
interface relax_osc_freq_meter_if #(
  parameter int unsigned CNT_W = 16
);
  logic             start;
  logic             mode;
  logic [2:0]       gate_sel;
  logic             byte_sel;
  logic [7:0]       dout;
  logic [CNT_W-1:0] count;
  logic             valid;
  logic             busy;
  logic             ovf;

  modport master (
    output start, mode, gate_sel, byte_sel,
    input  dout, count, valid, busy, ovf
  );

  modport slave (
    input  start, mode, gate_sel, byte_sel,
    output dout, count, valid, busy, ovf
  );
endinterface

// File: rtl/relax_osc_freq_meter.sv
// Gated rising-edge counter for the relaxation oscillator output, byte-muxed readout.
// Optional FREQ_METER_PRESCALE_EN: divide-by-16 prescaler ahead of the edge counter.
module relax_osc_freq_meter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   osc_in,
  relax_osc_freq_meter_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StArm, StGate, StLatch} state_e;

  localparam logic [CNT_W-1:0] CntMax  = '1;
  localparam logic [14:0]      GateAll = '1;

  state_e           state_q;
  logic             sync1_q, sync2_q, sync3_q;
  logic             edge_p;
  logic             cnt_inc;
  logic [14:0]      gate_cnt_q;
  logic [14:0]      gate_load;
  logic [CNT_W-1:0] edge_cnt_q;
  logic             sat_q;
  logic [CNT_W-1:0] count_q;
  logic             ovf_q;
  logic             valid_q;
  logic             busy_q;
  logic [15:0]      count_ext;

  // osc_in is asynchronous: two flops to settle, a third to find the rise
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= osc_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign edge_p = sync2_q & ~sync3_q;

`ifdef FREQ_METER_PRESCALE_EN
  logic [3:0] pre_q;
  assign cnt_inc = edge_p & (pre_q == 4'hF);
`else
  assign cnt_inc = edge_p;
`endif

  // N-1 = 2^(8+gate_sel)-1. Loading it in ARM makes the gate counter the only
  // state gate_sel influences, so later changes cannot disturb the window.
  assign gate_load = GateAll >> (3'd7 - bus.gate_sel);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      sat_q      <= 1'b0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
`ifdef FREQ_METER_PRESCALE_EN
      pre_q      <= '0;
`endif
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q <= StArm;
            busy_q  <= 1'b1;
          end
        end
        StArm: begin
          edge_cnt_q <= '0;
          sat_q      <= 1'b0;
          gate_cnt_q <= gate_load;
`ifdef FREQ_METER_PRESCALE_EN
          pre_q      <= '0;
`endif
          state_q    <= StGate;
        end
        StGate: begin
`ifdef FREQ_METER_PRESCALE_EN
          if (edge_p) begin
            pre_q <= pre_q + 4'd1;
          end
`endif
          if (cnt_inc) begin
            if (edge_cnt_q == CntMax) begin
              sat_q <= 1'b1;
            end else begin
              edge_cnt_q <= edge_cnt_q + 1'b1;
            end
          end
          if (gate_cnt_q == '0) begin
            state_q <= StLatch;
          end else begin
            gate_cnt_q <= gate_cnt_q - 15'd1;
          end
        end
        StLatch: begin
          count_q <= edge_cnt_q;
          ovf_q   <= sat_q;
          valid_q <= 1'b1;
          // live mode, so clearing it ends continuous runs after this window
          if (bus.mode) begin
            state_q <= StArm;
          end else begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign count_ext = 16'(count_q);

  assign bus.dout  = bus.byte_sel ? count_ext[15:8] : count_ext[7:0];
  assign bus.count = count_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;
  assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_relax_osc_freq_meter.sv
// Bench for relax_osc_freq_meter: 16-bit and 8-bit instances on shared stimulus,
// table vectors plus random windows against an edge-counting reference model.
module tb_relax_osc_freq_meter;

  localparam int HistLen = 100000;

  logic       clk = 1'b0;
  logic       rst;
  logic       osc_in;
  logic       start;
  logic       mode;
  logic       byte_sel;
  logic [2:0] gate_sel;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int osc_per = 0;
  int osc_ph  = 0;
  bit hist [HistLen];

  always #5 clk = ~clk;

  relax_osc_freq_meter_if #(.CNT_W(16)) bus16 ();
  relax_osc_freq_meter_if #(.CNT_W(8))  bus8 ();

  assign bus16.start    = start;
  assign bus16.mode     = mode;
  assign bus16.gate_sel = gate_sel;
  assign bus16.byte_sel = byte_sel;
  assign bus8.start     = start;
  assign bus8.mode      = mode;
  assign bus8.gate_sel  = gate_sel;
  assign bus8.byte_sel  = byte_sel;

  relax_osc_freq_meter #(.CNT_W(16)) dut16 (
    .clk    (clk),
    .rst    (rst),
    .osc_in (osc_in),
    .bus    (bus16)
  );

  relax_osc_freq_meter #(.CNT_W(8)) dut8 (
    .clk    (clk),
    .rst    (rst),
    .osc_in (osc_in),
    .bus    (bus8)
  );

  typedef struct {
    int per;
    int ph;
    int gs;
    int edges;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic osc_val(input int c);
    if (osc_per < 2) return 1'b0;
    return ((c + osc_ph) % osc_per) < (osc_per / 2);
  endfunction

  // One clock: record the osc_in value sampled at this edge, then set the next one.
  task automatic step();
    @(posedge clk);
    if (cyc < HistLen) hist[cyc] = osc_in;
    cyc++;
    #1;
    osc_in = osc_val(cyc);
  endtask

  // Rising transitions of osc_in as seen through the 2-cycle synchronizer during the
  // N gate cycles that follow a start sampled at edge t.
  function automatic int model_edges(input int t, input int n);
    int e = 0;
    for (int q = t + 2; q <= t + n + 1; q++) begin
      if (hist[q-2] && !hist[q-3]) e++;
    end
    return e;
  endfunction

  function automatic int scale(input int e);
`ifdef FREQ_METER_PRESCALE_EN
    return e / 16;
`else
    return e;
`endif
  endfunction

  function automatic int sat(input int e, input int w);
    int m = (1 << w) - 1;
    return (e > m) ? m : e;
  endfunction

  task automatic settle(input int per, input int ph);
    osc_per = per;
    osc_ph  = ph;
    osc_in  = osc_val(cyc);
    repeat (4) step();
  endtask

  task automatic kick(input string name, output int t);
    start = 1'b1;
    step();
    t = cyc - 1;
    start = 1'b0;
    check($sformatf("%s busy_after_start", name), bus16.busy, 1);
  endtask

  task automatic wait_valid(input string name, input int exp_at, output int at);
    at = -1;
    while (at < 0 && cyc <= exp_at + 20) begin
      step();
      if (bus16.valid === 1'b1) at = cyc - 1;
    end
    check($sformatf("%s valid_at", name), at, exp_at);
    check($sformatf("%s valid8", name), bus8.valid, 1);
  endtask

  task automatic check_result(input string name, input int e);
    int c16 = sat(e, 16);
    int c8  = sat(e, 8);
    check($sformatf("%s count16", name), bus16.count, c16);
    check($sformatf("%s ovf16", name), bus16.ovf, (e > 65535));
    check($sformatf("%s count8", name), bus8.count, c8);
    check($sformatf("%s ovf8", name), bus8.ovf, (e > 255));
    byte_sel = 1'b0;
    #1;
    check($sformatf("%s dout16_lo", name), bus16.dout, c16 & 255);
    check($sformatf("%s dout8_lo", name), bus8.dout, c8);
    byte_sel = 1'b1;
    #1;
    check($sformatf("%s dout16_hi", name), bus16.dout, (c16 >> 8) & 255);
    check($sformatf("%s dout8_hi", name), bus8.dout, 0);
    byte_sel = 1'b0;
  endtask

  // exp_e < 0 selects the reference model instead of a table constant.
  task automatic one_shot(input string name, input int gs, input int exp_e);
    int t, at, e, n;
    n = 1 << (8 + gs);
    gate_sel = gs[2:0];
    kick(name, t);
    wait_valid(name, t + n + 2, at);
    e = scale((exp_e < 0) ? model_edges(t, n) : exp_e);
    check_result(name, e);
    step();
    check($sformatf("%s valid_drop", name), bus16.valid, 0);
    check($sformatf("%s busy_drop", name), bus16.busy, 0);
  endtask

  task automatic quiet(input string name, input int n);
    int v = 0;
    repeat (n) begin
      step();
      if (bus16.valid === 1'b1 || bus8.valid === 1'b1) v++;
    end
    check($sformatf("%s extra_valids", name), v, 0);
    check($sformatf("%s busy_idle", name), bus16.busy, 0);
  endtask

  initial begin
    vec_t vecs [7];
    int t, at, n;

    vecs[0] = '{per: 16, ph: 3, gs: 0, edges: 16};
    vecs[1] = '{per: 8,  ph: 0, gs: 0, edges: 32};
    vecs[2] = '{per: 32, ph: 5, gs: 1, edges: 16};
    vecs[3] = '{per: 2,  ph: 1, gs: 1, edges: 256};
    vecs[4] = '{per: 0,  ph: 0, gs: 0, edges: 0};
    vecs[5] = '{per: 4,  ph: 2, gs: 2, edges: 256};
    vecs[6] = '{per: 2,  ph: 0, gs: 3, edges: 1024};

    rst = 1'b1; start = 1'b0; mode = 1'b0; byte_sel = 1'b0; gate_sel = 3'd0;
    osc_per = 2; osc_in = 1'b0;
    repeat (2) step();
    check("reset count16", bus16.count, 0);
    check("reset dout16", bus16.dout, 0);
    check("reset valid16", bus16.valid, 0);
    check("reset busy16", bus16.busy, 0);
    check("reset ovf16", bus16.ovf, 0);
    check("reset count8", bus8.count, 0);
    check("reset valid8", bus8.valid, 0);
    check("reset busy8", bus8.busy, 0);
    check("reset ovf8", bus8.ovf, 0);
    rst = 1'b0;
    step();
    check("idle busy", bus16.busy, 0);

    for (int i = 0; i < 7; i++) begin
      settle(vecs[i].per, vecs[i].ph);
      one_shot($sformatf("vec%0d", i), vecs[i].gs, vecs[i].edges);
      quiet($sformatf("vec%0d", i), 8);
    end

    for (int i = 0; i < 6; i++) begin
      settle(int'($urandom_range(2, 40)), int'($urandom_range(0, 63)));
      one_shot($sformatf("rnd%0d", i), int'($urandom_range(0, 2)), -1);
    end

    // Continuous: back-to-back windows every N+2, then mode cleared mid-window.
    settle(4, 1);
    mode = 1'b1;
    gate_sel = 3'd2;
    n = 1024;
    kick("cont", t);
    for (int k = 0; k < 3; k++) begin
      wait_valid($sformatf("cont%0d", k), t + n + 2, at);
      check_result($sformatf("cont%0d", k), scale(256));
      check($sformatf("cont%0d model", k), bus16.count, sat(scale(model_edges(t, n)), 16));
      t = at;
    end
    repeat (500) step();
    mode = 1'b0;
    check("cont busy_mid", bus16.busy, 1);
    wait_valid("cont_last", t + n + 2, at);
    check_result("cont_last", scale(256));
    quiet("cont_stop", 1100);

    // gate_sel changed inside the window must not stretch it.
    settle(16, 0);
    gate_sel = 3'd0;
    kick("gsel", t);
    repeat (50) step();
    gate_sel = 3'd7;
    wait_valid("gsel", t + 258, at);
    check_result("gsel", scale(16));
    quiet("gsel", 20);

    // start pulsed while busy is ignored.
    gate_sel = 3'd0;
    kick("busy_start", t);
    repeat (100) step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_valid("busy_start", t + 258, at);
    quiet("busy_start", 400);

    // Reset mid-GATE: no result, everything cleared.
    gate_sel = 3'd0;
    kick("mid_rst", t);
    repeat (100) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst count16", bus16.count, 0);
    check("mid_rst count8", bus8.count, 0);
    check("mid_rst ovf16", bus16.ovf, 0);
    check("mid_rst dout16", bus16.dout, 0);
    check("mid_rst busy", bus16.busy, 0);
    quiet("mid_rst", 400);
    check("mid_rst count_hold", bus16.count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
